mm2s_readback_checker: RTL and testbench

//  Read-back side of the DDR stream capture path. Issues AXI DataMover MM2S commands over consecutive
//  BTT-sized regions from BASE_ADDR, accepts the returned 32-bit AXI stream, and checks it against the

---
 rtl/mm2s_readback_checker_if.sv | 41 ++++
 rtl/mm2s_readback_checker.sv | 204 ++++++++++++++++++++
 tb/tb_mm2s_readback_checker.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mm2s_readback_checker_if.sv
// mm2s_readback_checker_if
//   Groups the three AXI-Stream channels between the read-back checker and
//   the DataMover MM2S engine.
//   master : checker side (issues commands, sinks status and read data)
//   slave  : DataMover side (sinks commands, sources status and read data)
// Signals
//   cmd_tdata[71:0] / cmd_tvalid / cmd_tready : MM2S command channel
//   sts_tdata[7:0]  / sts_tvalid / sts_tready : MM2S status channel
//   mm2s_tdata[31:0] / mm2s_tkeep[3:0] / mm2s_tlast / mm2s_tvalid / mm2s_tready
//                                             : read data stream
interface mm2s_readback_checker_if;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid;
  logic        sts_tready;
  logic [31:0] mm2s_tdata;
  logic [3:0]  mm2s_tkeep;
  logic        mm2s_tlast;
  logic        mm2s_tvalid;
  logic        mm2s_tready;

  modport master (
    output cmd_tdata, cmd_tvalid,
    input  cmd_tready,
    input  sts_tdata, sts_tvalid,
    output sts_tready,
    input  mm2s_tdata, mm2s_tkeep, mm2s_tlast, mm2s_tvalid,
    output mm2s_tready
  );

  modport slave (
    input  cmd_tdata, cmd_tvalid,
    output cmd_tready,
    output sts_tdata, sts_tvalid,
    input  sts_tready,
    output mm2s_tdata, mm2s_tkeep, mm2s_tlast, mm2s_tvalid,
    input  mm2s_tready
  );
endinterface

// File: rtl/mm2s_readback_checker.sv
// mm2s_readback_checker
//   Read-back half of the DDR capture path. Walks NUM_CMDS consecutive
//   BTT-byte regions starting at BASE_ADDR, issuing one MM2S command per
//   region, and checks the returned stream against the incrementing 32-bit
//   word pattern the S2MM generator wrote. The pattern counter runs on across
//   region boundaries. MM2S status is consumed and any bad status is latched.
// Ports
//   clk        : clock
//   reset      : synchronous, active-high; aborts any run immediately
//   start      : one-cycle run request, honoured only in IDLE or DONE
//   m          : command / status / read-data channels (master modport)
//   busy       : run in progress (CMD, DATA or STS)
//   done       : level, high once the run has completed
//   sts_err    : sticky, a bad status was seen this run
//   err_count  : beats with a data, tkeep or tlast mismatch (saturating)
//   word_count : beats accepted this run (wrapping)
module mm2s_readback_checker #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [22:0] BTT       = 23'h4_0000,
  parameter int          NUM_CMDS  = 16,
  parameter logic [3:0]  TAG       = 4'hA
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  mm2s_readback_checker_if.master    m,
  output logic                       busy,
  output logic                       done,
  output logic                       sts_err,
  output logic [31:0]                err_count,
  output logic [31:0]                word_count
);

  generate
    if (BTT == 23'd0 || BTT[1:0] != 2'b00) begin : g_bad_btt
      $error("mm2s_readback_checker: BTT must be a nonzero multiple of 4");
    end
    if (NUM_CMDS < 1) begin : g_bad_num_cmds
      $error("mm2s_readback_checker: NUM_CMDS must be at least 1");
    end
  endgenerate

  localparam logic [22:0] LAST_BEAT = {2'b00, BTT[22:2]} - 23'd1;
  localparam logic [31:0] LAST_IDX  = 32'(NUM_CMDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_STS,
    S_DONE
  } state_t;

  // Command word: {rsvd, tag, saddr, drr/eof/dsa, type=INCR, btt}
  function automatic logic [71:0] cmd_word(input logic [31:0] addr);
    return {4'b0000, TAG, addr, 8'h00, 1'b1, BTT};
  endfunction

  function automatic logic sts_is_bad(input logic [7:0] s);
    return !s[7] || (|s[6:4]) || (s[3:0] != TAG);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_expected;
  logic [31:0] r_cmd_idx;
  logic [22:0] r_beat;
  logic        r_sts_seen;
  logic [71:0] r_cmd_tdata;
  logic        r_cmd_tvalid;
  logic        r_sts_tready;
  logic        r_mm2s_tready;
  logic        r_busy;
  logic        r_done;
  logic        r_sts_err;
  logic [31:0] r_err_count;
  logic [31:0] r_word_count;

  logic        w_beat_hs;
  logic        w_sts_hs;
  logic        w_cmd_hs;
  logic        w_last_beat;
  logic        w_beat_err;
  logic [31:0] w_next_addr;

  assign w_beat_hs   = m.mm2s_tvalid & r_mm2s_tready;
  assign w_sts_hs    = m.sts_tvalid & r_sts_tready;
  assign w_cmd_hs    = r_cmd_tvalid & m.cmd_tready;
  assign w_last_beat = (r_beat == LAST_BEAT);
  // One flag per beat, so a beat with several faults is counted once.
  assign w_beat_err  = (m.mm2s_tdata != r_expected) ||
                       (m.mm2s_tkeep != 4'hF) ||
                       (m.mm2s_tlast != w_last_beat);
  assign w_next_addr = r_addr + {9'd0, BTT};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_addr        <= BASE_ADDR;
      r_expected    <= 32'd0;
      r_cmd_idx     <= 32'd0;
      r_beat        <= 23'd0;
      r_sts_seen    <= 1'b0;
      r_cmd_tdata   <= cmd_word(BASE_ADDR);
      r_cmd_tvalid  <= 1'b0;
      r_sts_tready  <= 1'b0;
      r_mm2s_tready <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sts_err     <= 1'b0;
      r_err_count   <= 32'd0;
      r_word_count  <= 32'd0;
    end else begin
      // Status may land any time sts_tready is up (DATA or STS); an early
      // status is remembered so STS does not wait for a second one.
      if (w_sts_hs) begin
        r_sts_seen <= 1'b1;
        if (sts_is_bad(m.sts_tdata)) begin
          r_sts_err <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_CMD;
            r_addr       <= BASE_ADDR;
            r_cmd_tdata  <= cmd_word(BASE_ADDR);
            r_cmd_tvalid <= 1'b1;
            r_expected   <= 32'd0;
            r_cmd_idx    <= 32'd0;
            r_err_count  <= 32'd0;
            r_word_count <= 32'd0;
            r_sts_err    <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end

        S_CMD: begin
          if (w_cmd_hs) begin
            r_state       <= S_DATA;
            r_cmd_tvalid  <= 1'b0;
            r_mm2s_tready <= 1'b1;
            r_sts_tready  <= 1'b1;
            r_beat        <= 23'd0;
            r_sts_seen    <= 1'b0;
          end
        end

        S_DATA: begin
          if (w_beat_hs) begin
            r_expected   <= r_expected + 32'd1;
            r_word_count <= r_word_count + 32'd1;
            r_beat       <= r_beat + 23'd1;
            if (w_beat_err) begin
              r_err_count <= sat_inc(r_err_count);
            end
            // Region length is fixed by BTT; tlast is only checked, never
            // used to end the region.
            if (w_last_beat) begin
              r_state       <= S_STS;
              r_mm2s_tready <= 1'b0;
            end
          end
        end

        S_STS: begin
          if (r_sts_seen || w_sts_hs) begin
            r_sts_tready <= 1'b0;
            if (r_cmd_idx == LAST_IDX) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state      <= S_CMD;
              r_cmd_idx    <= r_cmd_idx + 32'd1;
              r_addr       <= w_next_addr;
              r_cmd_tdata  <= cmd_word(w_next_addr);
              r_cmd_tvalid <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m.cmd_tdata   = r_cmd_tdata;
  assign m.cmd_tvalid  = r_cmd_tvalid;
  assign m.sts_tready  = r_sts_tready;
  assign m.mm2s_tready = r_mm2s_tready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign sts_err       = r_sts_err;
  assign err_count     = r_err_count;
  assign word_count    = r_word_count;

endmodule

// File: tb/tb_mm2s_readback_checker.sv
// tb_mm2s_readback_checker
//   Drives the checker (BTT=16, NUM_CMDS=2) with a DataMover model. Expected
//   commands and end-of-run results are queued when each run is launched; a
//   monitor pops them when the DUT hands off a command or raises done.
module tb_mm2s_readback_checker;

  localparam logic [71:0] CMD0 = 72'h0A_00000000_00_800010;
  localparam logic [71:0] CMD1 = 72'h0A_00000010_00_800010;

  typedef struct {
    logic [31:0] err;
    logic [31:0] word;
    logic        serr;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        sts_err;
  logic [31:0] err_count;
  logic [31:0] word_count;

  int n_vec  = 0;
  int n_miss = 0;

  logic [71:0] exp_cmd_q[$];
  res_t        exp_res_q[$];

  mm2s_readback_checker_if bus ();

  mm2s_readback_checker #(
    .BASE_ADDR (32'h0000_0000),
    .BTT       (23'd16),
    .NUM_CMDS  (2),
    .TAG       (4'hA)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .m          (bus),
    .busy       (busy),
    .done       (done),
    .sts_err    (sts_err),
    .err_count  (err_count),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: compare every accepted command and every completed run.
  logic done_q = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.cmd_tvalid && bus.cmd_tready) begin
          if (exp_cmd_q.size() == 0) timeout("cmd_unexpected");
          else chk("cmd_tdata", bus.cmd_tdata, exp_cmd_q.pop_front());
        end
        if (done && !done_q) begin
          if (exp_res_q.size() == 0) begin
            timeout("done_unexpected");
          end else begin
            res_t r;
            r = exp_res_q.pop_front();
            chk("err_count", 72'(err_count), 72'(r.err));
            chk("word_count", 72'(word_count), 72'(r.word));
            chk("sts_err", 72'(sts_err), 72'(r.serr));
          end
        end
      end
      done_q = done;
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Accept one command, optionally stalling cmd_tready for 'delay' cycles.
  task automatic do_cmd(input int delay, input logic [71:0] exp);
    int t = 0;
    while (!bus.cmd_tvalid && t < 200) begin @(posedge clk); #1; t++; end
    if (!bus.cmd_tvalid) begin timeout("cmd_tvalid"); return; end
    for (int i = 0; i < delay; i++) begin
      chk("hold_cmd_tvalid", 72'(bus.cmd_tvalid), 72'd1);
      chk("hold_cmd_tdata", bus.cmd_tdata, exp);
      chk("hold_no_mm2s_tready", 72'(bus.mm2s_tready), 72'd0);
      @(posedge clk); #1;
    end
    bus.cmd_tready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_tready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    bus.mm2s_tdata  = d;
    bus.mm2s_tkeep  = k;
    bus.mm2s_tlast  = l;
    bus.mm2s_tvalid = 1'b1;
    while (!bus.mm2s_tready && t < 200) begin @(posedge clk); #1; t++; end
    if (!bus.mm2s_tready) begin timeout("mm2s_tready"); bus.mm2s_tvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.mm2s_tvalid = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] s);
    int t = 0;
    bus.sts_tdata  = s;
    bus.sts_tvalid = 1'b1;
    while (!bus.sts_tready && t < 200) begin @(posedge clk); #1; t++; end
    if (!bus.sts_tready) begin timeout("sts_tready"); bus.sts_tvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.sts_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 500) begin @(posedge clk); #1; t++; end
    if (!done) timeout("done");
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // One full two-region run. Global beat g (0..7) carries data g unless
  // g==bad_beat; tkeep is 4'h7 on keep_beat; tlast comes from last_mask[g].
  task automatic run_case(input int delay, input int bad_beat, input logic [31:0] bad_val,
                          input int keep_beat, input logic [7:0] last_mask,
                          input logic [7:0] sts0, input logic [7:0] sts1, input logic early,
                          input logic [31:0] e_err, input logic e_serr);
    res_t r;
    r.err = e_err; r.word = 32'd8; r.serr = e_serr;
    exp_cmd_q.push_back(CMD0);
    exp_cmd_q.push_back(CMD1);
    exp_res_q.push_back(r);
    start_pulse();
    for (int c = 0; c < 2; c++) begin
      do_cmd((c == 0) ? delay : 0, (c == 0) ? CMD0 : CMD1);
      if (early) send_sts((c == 0) ? sts0 : sts1);
      for (int b = 0; b < 4; b++) begin
        int g;
        g = c * 4 + b;
        send_beat((g == bad_beat) ? bad_val : 32'(g),
                  (g == keep_beat) ? 4'h7 : 4'hF, last_mask[g]);
      end
      if (!early) send_sts((c == 0) ? sts0 : sts1);
    end
    wait_done();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.cmd_tready  = 1'b0;
    bus.sts_tdata   = 8'h00;
    bus.sts_tvalid  = 1'b0;
    bus.mm2s_tdata  = 32'd0;
    bus.mm2s_tkeep  = 4'hF;
    bus.mm2s_tlast  = 1'b0;
    bus.mm2s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_handshakes", 72'({bus.cmd_tvalid, bus.sts_tready, bus.mm2s_tready}), 72'd0);
    chk("rst_flags", 72'({busy, done, sts_err}), 72'd0);
    chk("rst_counts", 72'({err_count, word_count}), 72'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean run
    run_case(0, -1, 32'd0, -1, 8'b1000_1000, 8'h8A, 8'h8A, 1'b0, 32'd0, 1'b0);
    // Bad data on beat 5; beats 6,7 still expected to be 6,7
    run_case(0, 5, 32'h0000_DEAD, -1, 8'b1000_1000, 8'h8A, 8'h8A, 1'b0, 32'd1, 1'b0);
    // SLVERR on first status; run still completes
    run_case(0, -1, 32'd0, -1, 8'b1000_1000, 8'hCA, 8'h8A, 1'b0, 32'd0, 1'b1);
    // Wrong tag on second status
    run_case(0, -1, 32'd0, -1, 8'b1000_1000, 8'h8A, 8'h85, 1'b0, 32'd0, 1'b1);
    // cmd_tready held low for 10 cycles on first command
    run_case(10, -1, 32'd0, -1, 8'b1000_1000, 8'h8A, 8'h8A, 1'b0, 32'd0, 1'b0);
    // tlast on beat 1 and missing on beat 3, status arrives early
    run_case(0, -1, 32'd0, -1, 8'b1000_0010, 8'h8A, 8'h8A, 1'b1, 32'd2, 1'b0);
    // Bad data and bad tkeep on the same beat count once
    run_case(0, 2, 32'h1234_5678, 2, 8'b1000_1000, 8'h8A, 8'h8A, 1'b0, 32'd1, 1'b0);

    // Reset while beat 2 is on the bus
    exp_cmd_q.push_back(CMD0);
    start_pulse();
    do_cmd(0, CMD0);
    send_beat(32'd0, 4'hF, 1'b0);
    send_beat(32'd1, 4'hF, 1'b0);
    chk("busy_mid_run", 72'(busy), 72'd1);
    chk("word_count_mid_run", 72'(word_count), 72'd2);
    bus.mm2s_tdata  = 32'd2;
    bus.mm2s_tvalid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_handshakes", 72'({bus.cmd_tvalid, bus.sts_tready, bus.mm2s_tready}), 72'd0);
    chk("midrst_flags", 72'({busy, done, sts_err}), 72'd0);
    chk("midrst_counts", 72'({err_count, word_count}), 72'd0);
    reset = 1'b0;
    bus.mm2s_tvalid = 1'b0;
    @(posedge clk); #1;
    run_case(0, -1, 32'd0, -1, 8'b1000_1000, 8'h8A, 8'h8A, 1'b0, 32'd0, 1'b0);

    chk("cmd_queue_drained", 72'(exp_cmd_q.size()), 72'd0);
    chk("result_queue_drained", 72'(exp_res_q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
